// File: rtl/gt_miss_handler.sv
// Miss/refill controller for the GT cache: optional dirty-victim write-back, then line read and fill.
// Define GT_MISS_STATS_EN to add the missCount/stallCycles/wbCount statistics outputs.
module gt_miss_handler #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int OFF_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              miss,
  input  logic [ADDR_W-1:0] lineAddr,
  input  logic              evictValid,
  input  logic [ADDR_W-1:0] evictAddr,
  input  logic [LINE_W-1:0] evictData,
  output logic              memReqValid,
  output logic              memReqWrite,
  output logic [ADDR_W-1:0] memReqAddr,
  output logic [LINE_W-1:0] memReqData,
  input  logic              memReqReady,
  input  logic              memRespValid,
  input  logic [LINE_W-1:0] memRespData,
  output logic              fillValid,
  output logic [ADDR_W-1:0] fillAddr,
  output logic [LINE_W-1:0] memData,
  output logic              stall
`ifdef GT_MISS_STATS_EN
  ,
  output logic [31:0]       missCount,
  output logic [31:0]       stallCycles,
  output logic [31:0]       wbCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_FILL
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_W-1:0] r_missAddr;
  logic [ADDR_W-1:0] r_evictAddr;
  logic [LINE_W-1:0] r_evictData;

  logic              r_memReqValid;
  logic              r_memReqWrite;
  logic [ADDR_W-1:0] r_memReqAddr;
  logic [LINE_W-1:0] r_memReqData;
  logic              r_fillValid;
  logic [ADDR_W-1:0] r_fillAddr;
  logic [LINE_W-1:0] r_memData;
  logic              r_stall;

  logic [ADDR_W-1:0] w_alignedLine;
  logic [ADDR_W-1:0] w_alignedEvict;
  logic [ADDR_W-1:0] w_missLine;
  logic [ADDR_W-1:0] w_victimAddr;
  logic [LINE_W-1:0] w_victimData;
  logic              w_missAccept;
  logic              w_unusedOffsets;

  assign w_alignedLine   = {lineAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_alignedEvict  = {evictAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unusedOffsets = ^{lineAddr[OFF_W-1:0], evictAddr[OFF_W-1:0]};
  assign w_missAccept    = (r_state == S_IDLE) && miss;

  // On the accepting edge the latches are not yet loaded, so requests take the inputs directly
  assign w_missLine   = (r_state == S_IDLE) ? w_alignedLine  : r_missAddr;
  assign w_victimAddr = (r_state == S_IDLE) ? w_alignedEvict : r_evictAddr;
  assign w_victimData = (r_state == S_IDLE) ? evictData      : r_evictData;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:    if (miss) w_nextState = evictValid ? S_WB_REQ : S_RD_REQ;
      S_WB_REQ:  if (memReqReady) w_nextState = S_RD_REQ;
      S_RD_REQ:  if (memReqReady) w_nextState = S_RD_WAIT;
      S_RD_WAIT: if (memRespValid) w_nextState = S_FILL;
      S_FILL:    w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_missAddr  <= '0;
      r_evictAddr <= '0;
      r_evictData <= '0;
    end else if (w_missAccept) begin
      r_missAddr <= w_alignedLine;
      if (evictValid) begin
        r_evictAddr <= w_alignedEvict;
        r_evictData <= evictData;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_memReqValid <= 1'b0;
      r_memReqWrite <= 1'b0;
      r_memReqAddr  <= '0;
      r_memReqData  <= '0;
      r_fillValid   <= 1'b0;
      r_fillAddr    <= '0;
      r_memData     <= '0;
      r_stall       <= 1'b0;
    end else begin
      r_memReqValid <= (w_nextState == S_WB_REQ) || (w_nextState == S_RD_REQ);
      r_memReqWrite <= (w_nextState == S_WB_REQ);
      if (w_nextState == S_WB_REQ) begin
        r_memReqAddr <= w_victimAddr;
        r_memReqData <= w_victimData;
      end else if (w_nextState == S_RD_REQ) begin
        r_memReqAddr <= w_missLine;
        r_memReqData <= '0;
      end else begin
        r_memReqAddr <= '0;
        r_memReqData <= '0;
      end
      r_fillValid <= (w_nextState == S_FILL);
      if ((r_state == S_RD_WAIT) && memRespValid) begin
        r_memData  <= memRespData;
        r_fillAddr <= r_missAddr;
      end
      // Stall is held one extra cycle past FILL so the core sees the installed line
      r_stall <= (w_nextState != S_IDLE) || (r_state == S_FILL);
    end
  end

  assign memReqValid = r_memReqValid;
  assign memReqWrite = r_memReqWrite;
  assign memReqAddr  = r_memReqAddr;
  assign memReqData  = r_memReqData;
  assign fillValid   = r_fillValid;
  assign fillAddr    = r_fillAddr;
  assign memData     = r_memData;
  assign stall       = r_stall;

`ifdef GT_MISS_STATS_EN
  logic [31:0] r_missCount;
  logic [31:0] r_stallCycles;
  logic [31:0] r_wbCount;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_missCount   <= '0;
      r_stallCycles <= '0;
      r_wbCount     <= '0;
    end else begin
      if (w_missAccept && (r_missCount != 32'hFFFF_FFFF)) r_missCount <= r_missCount + 32'd1;
      if (r_stall && (r_stallCycles != 32'hFFFF_FFFF)) r_stallCycles <= r_stallCycles + 32'd1;
      if ((r_state == S_WB_REQ) && memReqReady && (r_wbCount != 32'hFFFF_FFFF)) begin
        r_wbCount <= r_wbCount + 32'd1;
      end
    end
  end

  assign missCount   = r_missCount;
  assign stallCycles = r_stallCycles;
  assign wbCount     = r_wbCount;
`endif

endmodule

// File: tb/tb_gt_miss_handler.sv
// Self-checking bench for gt_miss_handler: directed and randomized misses against a transaction-level model.
module tb_gt_miss_handler;

  logic         CLK;
  logic         RST;
  logic         miss;
  logic [31:0]  lineAddr;
  logic         evictValid;
  logic [31:0]  evictAddr;
  logic [255:0] evictData;
  logic         memReqValid;
  logic         memReqWrite;
  logic [31:0]  memReqAddr;
  logic [255:0] memReqData;
  logic         memReqReady;
  logic         memRespValid;
  logic [255:0] memRespData;
  logic         fillValid;
  logic [31:0]  fillAddr;
  logic [255:0] memData;
  logic         stall;
`ifdef GT_MISS_STATS_EN
  logic [31:0]  missCount;
  logic [31:0]  stallCycles;
  logic [31:0]  wbCount;
`endif

  gt_miss_handler dut (
    .CLK(CLK), .RST(RST), .miss(miss), .lineAddr(lineAddr),
    .evictValid(evictValid), .evictAddr(evictAddr), .evictData(evictData),
    .memReqValid(memReqValid), .memReqWrite(memReqWrite), .memReqAddr(memReqAddr),
    .memReqData(memReqData), .memReqReady(memReqReady), .memRespValid(memRespValid),
    .memRespData(memRespData), .fillValid(fillValid), .fillAddr(fillAddr),
    .memData(memData), .stall(stall)
`ifdef GT_MISS_STATS_EN
    , .missCount(missCount), .stallCycles(stallCycles), .wbCount(wbCount)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } req_t;

  req_t         seenReqs[$];
  int           checksDone = 0;
  int           checksPassed = 0;
  longint       expMiss = 0;
  longint       expWb = 0;
  longint       expStall = 0;
  logic [255:0] lastFill = '0;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  function automatic logic [31:0] lineOf(input logic [31:0] a);
    return (a >> 5) << 5;
  endfunction

  // One complete miss from IDLE; memory delays: d1/d2 ready-low cycles, d3 cycles from read acceptance to response
  task automatic applyStimulus(input logic [31:0] addr, input logic ev, input logic [31:0] eAddr,
                               input logic [255:0] eData, input int d1, input int d2, input int d3,
                               input logic [255:0] respData, input bit injectMiss);
    int           stallCnt = 0;
    int           held = 0;
    int           fills = 0;
    int           sinceRd = 0;
    bit           rdAcc = 0;
    logic [31:0]  heldAddr = '0;
    logic [31:0]  fillA = '0;
    logic [255:0] fillD = '0;
    int           expStallHere;
    seenReqs.delete();
    miss = 1'b1; lineAddr = addr; evictValid = ev; evictAddr = eAddr; evictData = eData;
    memReqReady = 1'b0;
    @(negedge CLK);
    for (int cyc = 0; cyc < 300; cyc++) begin
      miss = 1'b0; memRespValid = 1'b0; memReqReady = 1'b0;
      evictValid = 1'(($urandom));
      evictAddr = $urandom;
      if (!stall) break;
      stallCnt++;
      if (fillValid) begin
        fills++; fillA = fillAddr; fillD = memData;
      end
      if (rdAcc) begin
        sinceRd++;
        if (sinceRd == d3) begin
          memRespValid = 1'b1; memRespData = respData;
        end
      end
      if (memReqValid) begin
        if (held == 0) heldAddr = memReqAddr;
        else checkOutput("reqAddrHeld", {224'd0, memReqAddr}, {224'd0, heldAddr});
        if (held >= (memReqWrite ? d1 : d2)) begin
          memReqReady = 1'b1;
          seenReqs.push_back('{memReqWrite, memReqAddr, memReqData});
          held = 0;
          if (!memReqWrite) begin
            rdAcc = 1; sinceRd = 0;
          end
        end else begin
          held++;
        end
      end
      if (injectMiss && rdAcc && (fills == 0) && !memReqValid && !memRespValid) begin
        miss = 1'b1; lineAddr = $urandom; evictValid = 1'b1;
      end
      @(negedge CLK);
    end
    miss = 1'b0; memRespValid = 1'b0; memReqReady = 1'b0; evictValid = 1'b0;
    expStallHere = (ev ? 1 + d1 : 0) + 1 + d2 + d3 + 2;
    checkOutput("stallCycles", 256'(stallCnt), 256'(expStallHere));
    checkOutput("reqCount", 256'(seenReqs.size()), ev ? 256'd2 : 256'd1);
    if (ev && seenReqs.size() >= 1) begin
      checkOutput("wbWrite", {255'd0, seenReqs[0].wr}, 256'd1);
      checkOutput("wbAddr", {224'd0, seenReqs[0].addr}, {224'd0, lineOf(eAddr)});
      checkOutput("wbData", seenReqs[0].data, eData);
    end
    if (seenReqs.size() >= 1) begin
      checkOutput("rdWrite", {255'd0, seenReqs[seenReqs.size()-1].wr}, 256'd0);
      checkOutput("rdAddr", {224'd0, seenReqs[seenReqs.size()-1].addr}, {224'd0, lineOf(addr)});
      checkOutput("rdData", seenReqs[seenReqs.size()-1].data, 256'd0);
    end
    checkOutput("fillCount", 256'(fills), 256'd1);
    checkOutput("fillAddr", {224'd0, fillA}, {224'd0, lineOf(addr)});
    checkOutput("fillData", fillD, respData);
    checkOutput("memDataHeld", memData, respData);
    checkOutput("idleNoFill", {255'd0, fillValid}, 256'd0);
    lastFill = respData;
    expMiss++;
    if (ev) expWb++;
    expStall += expStallHere;
  endtask

  initial begin
    logic [255:0] rnd;
    bit           anyFill;
    bit           anyStall;
    RST = 1'b1; miss = 1'b0; lineAddr = '0; evictValid = 1'b0; evictAddr = '0; evictData = '0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
    repeat (2) @(negedge CLK);
    checkOutput("rstStall", {255'd0, stall}, 256'd0);
    checkOutput("rstReqValid", {255'd0, memReqValid}, 256'd0);
    checkOutput("rstFillValid", {255'd0, fillValid}, 256'd0);
    checkOutput("rstMemData", memData, 256'd0);
    RST = 1'b0;
    @(negedge CLK);

    $display("[TB] clean miss");
    applyStimulus(32'h0000_1234, 1'b0, 32'h0, 256'h0, 0, 0, 2, {32{8'hA5}}, 1'b0);
    $display("[TB] dirty miss");
    applyStimulus(32'h0000_4444, 1'b1, 32'h0000_8000, 256'h1, 0, 0, 1, {8{32'hDEAD_BEEF}}, 1'b0);
    $display("[TB] read backpressure");
    applyStimulus(32'h0000_ABCD, 1'b0, 32'h0, 256'h0, 0, 3, 1, {16{16'h1357}}, 1'b0);

    $display("[TB] spurious response in IDLE, spurious miss in RD_WAIT");
    memRespValid = 1'b1; memRespData = {8{32'hBAD0_BAD0}};
    @(negedge CLK);
    memRespValid = 1'b0;
    @(negedge CLK);
    checkOutput("idleRespNoFill", {255'd0, fillValid}, 256'd0);
    checkOutput("idleRespNoStall", {255'd0, stall}, 256'd0);
    checkOutput("idleRespMemData", memData, lastFill);
    applyStimulus(32'h0001_0F0F, 1'b0, 32'h0, 256'h0, 0, 0, 4, {4{64'h0123_4567_89AB_CDEF}}, 1'b1);

    $display("[TB] reset in RD_WAIT");
    miss = 1'b1; lineAddr = 32'h0000_2000; evictValid = 1'b0;
    @(negedge CLK);
    miss = 1'b0; memReqReady = 1'b1;
    @(negedge CLK);
    memReqReady = 1'b0;
    #2 RST = 1'b1;
    #1;
    checkOutput("midRstStall", {255'd0, stall}, 256'd0);
    checkOutput("midRstReqValid", {255'd0, memReqValid}, 256'd0);
    @(negedge CLK);
    RST = 1'b0;
    memRespValid = 1'b1; memRespData = {8{32'hFACE_FACE}};
    anyFill = 0; anyStall = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      memRespValid = 1'b0;
      anyFill |= fillValid;
      anyStall |= stall;
    end
    checkOutput("postRstNoFill", {255'd0, anyFill}, 256'd0);
    checkOutput("postRstNoStall", {255'd0, anyStall}, 256'd0);
    checkOutput("postRstMemData", memData, 256'd0);
    expMiss = 0; expWb = 0; expStall = 0;

    $display("[TB] randomized misses");
    for (int n = 0; n < 24; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus($urandom, 1'($urandom), $urandom,
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                    rnd, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

`ifdef GT_MISS_STATS_EN
    checkOutput("statMiss", {224'd0, missCount}, 256'(expMiss));
    checkOutput("statWb", {224'd0, wbCount}, 256'(expWb));
    checkOutput("statStall", {224'd0, stallCycles}, 256'(expStall));
`endif

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
